// File: rtl/servo_pkg.sv
// Shared constants, widths and FSM encoding for the servo slew controller.
package servo_pkg;
  localparam int ANGLE_W        = 8;
  localparam int STEP_W         = 4;
  localparam int CNT_W          = 21;

  localparam int FRAME_CYCLES   = 2_000_000;
  localparam int BASE_CYCLES    = 100_000;
  localparam int CYCLES_PER_DEG = 555;
  localparam int ANGLE_MAX      = 180;
  localparam int RESET_ANGLE    = 90;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    HOLD     = 2'd1,
    SLEW     = 2'd2
  } state_t;
endpackage

// File: rtl/servo_slew_controller_if.sv
// Target-angle command channel: valid/ready handshake carrying angle and step.
interface servo_slew_controller_if;
  import servo_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  logic [ANGLE_W-1:0] cmd_angle;
  logic [STEP_W-1:0]  cmd_step;

  modport master (output cmd_valid, cmd_angle, cmd_step, input cmd_ready);
  modport slave  (input cmd_valid, cmd_angle, cmd_step, output cmd_ready);
endinterface

// File: rtl/servo_frame_timer.sv
// PWM frame counter: wraps every FRAME_CYCLES, flags the last cycle of each
// frame and drives the pin high for the first `width` counts of the frame.
module servo_frame_timer
  import servo_pkg::*;
#(
  parameter int FRAME_CYCLES = servo_pkg::FRAME_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [CNT_W-1:0] width,
  output logic             tick,
  output logic             pwm
);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRELAST = CNT_W'(FRAME_CYCLES - 2);

  logic [CNT_W-1:0] cnt;

  // Counter, tick and pin are all registered; tick is set one count early so
  // it lines up with cnt == LAST. Dropping run parks everything at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
      pwm  <= 1'b0;
    end else if (!run) begin
      cnt  <= '0;
      tick <= 1'b0;
      pwm  <= 1'b0;
    end else begin
      cnt  <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
      tick <= (cnt == PRELAST);
      pwm  <= (cnt < width);
    end
  end
endmodule

// File: rtl/servo_slew_controller.sv
// Single-channel servo sequencer: accepts target angles, slews the encoded
// angle toward the target once per PWM frame and converts it to a pulse width.
module servo_slew_controller
  import servo_pkg::*;
#(
  parameter int FRAME_CYCLES   = servo_pkg::FRAME_CYCLES,
  parameter int BASE_CYCLES    = servo_pkg::BASE_CYCLES,
  parameter int CYCLES_PER_DEG = servo_pkg::CYCLES_PER_DEG,
  parameter int ANGLE_MAX      = servo_pkg::ANGLE_MAX,
  parameter int RESET_ANGLE    = servo_pkg::RESET_ANGLE
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  servo_slew_controller_if.slave  cmd,
  output logic                    pwm_out,
  output logic [ANGLE_W-1:0]      cur_angle,
  output logic                    busy,
  output logic                    frame_tick
);
  localparam logic [9:0]         CPD_W   = 10'(CYCLES_PER_DEG);
  localparam logic [CNT_W-1:0]   BASE_W  = CNT_W'(BASE_CYCLES);
  localparam logic [ANGLE_W-1:0] AMAX    = ANGLE_W'(ANGLE_MAX);
  localparam logic [ANGLE_W-1:0] RST_A   = ANGLE_W'(RESET_ANGLE);
  localparam logic [CNT_W-1:0]   RESET_W = CNT_W'(BASE_CYCLES + CYCLES_PER_DEG * RESET_ANGLE);

  // 8x10 product fits 18 bits; zero-extend before adding the base width.
  function automatic logic [CNT_W-1:0] width_of(input logic [ANGLE_W-1:0] a);
    logic [17:0] prod;
    prod = {10'b0, a} * {8'b0, CPD_W};
    return BASE_W + {3'b0, prod};
  endfunction

  state_t             state_q, state_n;
  logic [ANGLE_W-1:0] cur_q, cur_n, tgt_q, tgt_n, slew_ang, clamp_ang;
  logic [STEP_W-1:0]  step_q, step_n;
  logic [CNT_W-1:0]   width_q, width_n;
  logic               ready_q, busy_q;
  logic               run, tick, boundary, accept;
  logic signed [8:0]  diff;
  logic [8:0]         mag;

  assign run       = enable && (state_q != DISABLED);
  assign boundary  = tick && enable;
  assign accept    = cmd.cmd_valid && ready_q;
  assign clamp_ang = (cmd.cmd_angle > AMAX) ? AMAX : cmd.cmd_angle;

  assign cmd.cmd_ready = ready_q;
  assign busy          = busy_q;
  assign cur_angle     = cur_q;
  assign frame_tick    = tick;

  // Angle the next boundary moves to: land on target when close enough (or
  // step is 0), otherwise one step toward it. 9-bit signed diff never wraps.
  always_comb begin
    diff = $signed({1'b0, tgt_q}) - $signed({1'b0, cur_q});
    mag  = diff[8] ? $unsigned(-diff) : $unsigned(diff);
    if (step_q == '0 || mag <= {5'b0, step_q})
      slew_ang = tgt_q;
    else if (!diff[8])
      slew_ang = cur_q + {4'b0, step_q};
    else
      slew_ang = cur_q - {4'b0, step_q};
  end

  // FSM next state plus target/step/angle/width updates.
  always_comb begin
    state_n = state_q;
    cur_n   = cur_q;
    tgt_n   = tgt_q;
    step_n  = step_q;
    width_n = width_q;
    case (state_q)
      DISABLED: begin
        if (enable) state_n = (tgt_q == cur_q) ? HOLD : SLEW;
      end
      HOLD: begin
        // Disable wins over a same-cycle accept; the slew target is parked.
        if (!enable) begin
          state_n = DISABLED;
          tgt_n   = cur_q;
        end else begin
          // A same-cycle boundary still sees the old target.
          if (boundary) begin
            cur_n   = slew_ang;
            width_n = width_of(slew_ang);
          end
          if (accept) begin
            tgt_n  = clamp_ang;
            step_n = cmd.cmd_step;
            if (clamp_ang != cur_q) state_n = SLEW;
          end
        end
      end
      SLEW: begin
        if (!enable) begin
          state_n = DISABLED;
          tgt_n   = cur_q;
        end else if (boundary) begin
          cur_n   = slew_ang;
          width_n = width_of(slew_ang);
          if (slew_ang == tgt_q) state_n = HOLD;
        end
      end
      default: state_n = DISABLED;
    endcase
  end

  // State and datapath registers; ready/busy are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DISABLED;
      cur_q   <= RST_A;
      tgt_q   <= RST_A;
      step_q  <= '0;
      width_q <= RESET_W;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cur_q   <= cur_n;
      tgt_q   <= tgt_n;
      step_q  <= step_n;
      width_q <= width_n;
      ready_q <= (state_n == HOLD);
      busy_q  <= (state_n == SLEW);
    end
  end

  servo_frame_timer #(.FRAME_CYCLES(FRAME_CYCLES)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .width (width_q),
    .tick  (tick),
    .pwm   (pwm_out)
  );
endmodule

// File: doc/servo_slew_controller.md
# servo_slew_controller

Sequences a single hobby-servo channel: accepts target-angle commands over a valid/ready handshake and slews the commanded angle toward the target by a programmable step once per 20 ms PWM frame. Converts the current angle to a pulse width of BASE_CYCLES + CYCLES_PER_DEG × angle and drives the PWM pin. Sits between the motion-command logic (UART/button front end) and the servo output pin.

## Interface
- FRAME_CYCLES, 2_000_000, PWM period in clk cycles (20 ms at 100 MHz)
- BASE_CYCLES, 100_000, pulse width at angle 0 (1 ms)
- CYCLES_PER_DEG, 555, pulse-width increment per degree
- ANGLE_MAX, 180, upper clamp on commanded angle
- RESET_ANGLE, 90, power-on angle
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  1 = generate PWM frames; 0 = output parked low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command can be accepted this cycle
- cmd_angle  in  8  target angle in degrees; values above ANGLE_MAX are clamped
- cmd_step  in  4  degrees per frame; 0 = jump in one frame
- pwm_out  out  1  servo PWM pin, registered
- cur_angle  out  8  angle the current/next frame encodes
- busy  out  1  slew in progress
- frame_tick  out  1  one-cycle pulse on the last cycle of each frame

## Operation
- States: DISABLED, HOLD, SLEW.
- DISABLED:
  - pwm_out = 0, frame counter held at 0, cmd_ready = 0.
  - enable = 1 → the state becomes HOLD if target == cur_angle, else SLEW. Frame counter starts at 0 the next cycle.
- HOLD:
  - cmd_ready = 1, busy = 0.
  - On accept (cmd_valid && cmd_ready), target ← min(cmd_angle, ANGLE_MAX) and step ← cmd_step.
  - If the clamped target ≠ cur_angle, go to SLEW. Otherwise stay in HOLD.
- SLEW:
  - cmd_ready = 0, busy = 1. cmd_valid is ignored; the requester holds it until ready.
- Frame boundary (counter == FRAME_CYCLES−1) in HOLD or SLEW:
  - cur_next = target if step == 0 or |target − cur| ≤ step. Otherwise cur_next = cur ± step, moving toward target.
  - cur_angle ← cur_next, and pulse width ← BASE_CYCLES + CYCLES_PER_DEG × cur_next.
  - SLEW → HOLD when cur_next == target.
- PWM: pwm_out = 1 while counter < width, else 0.
- Arithmetic:
  - Width and counter are 21 bits unsigned (max width 199,900; max count 1,999,999).
  - Product computed as 8×10 → 18 bits, zero-extended before the add.
  - Angle difference is computed 9-bit signed. There is no wrap.
- enable falls in HOLD or SLEW:
  - Next cycle the state is DISABLED and pwm_out = 0.
  - target ← cur_angle (the slew is aborted) and the counter clears to 0.
  - cur_angle and the pulse-width register are retained.
- Accept and frame boundary in the same cycle (HOLD): the boundary uses the old target; the new target is acted on from the next boundary.
- Reset (async, rst_n low) values:
  - state = DISABLED, pwm_out = 0, cmd_ready = 0, busy = 0, frame_tick = 0.
  - cur_angle = target = RESET_ANGLE, step = 0, width = 149,950, counter = 0.

## Timing
- All outputs are registered.
- cmd_ready and busy change the cycle after an accept or a boundary.
- A new angle takes effect on pwm_out at the first cycle of the frame after the boundary that updates cur_angle. Worst-case latency from accept to new width is one full frame + 1 cycle.
- Frame length is exactly FRAME_CYCLES. frame_tick is high on cycle FRAME_CYCLES−1 only.
- From enable rising: pwm_out goes high 2 cycles later, at counter = 0, and stays high for exactly width cycles.

## Structure
- servo_pkg holds:
  - the constants FRAME_CYCLES, BASE_CYCLES, CYCLES_PER_DEG, ANGLE_MAX and RESET_ANGLE as defaults;
  - the state enum;
  - width constants (ANGLE_W = 8, CNT_W = 21).
- Sub-module servo_frame_timer holds:
  - the 21-bit frame counter, the frame_tick generator and the pwm compare;
  - inputs: run, width. Outputs: tick, pwm.
- The top level holds the FSM, the slew arithmetic and the width computation.

## Test plan
- Reset, then enable = 1:
  - cur_angle = 90 and pwm_out = 0 before enable.
  - Each frame is 2,000,000 cycles with a high time of 149,950 cycles. frame_tick fires once per frame.
- In HOLD, send cmd_angle = 0, cmd_step = 0:
  - busy stays high until the next boundary.
  - The following frame has a high time of 100,000. cmd_ready returns to 1.
- In HOLD at 90, send cmd_angle = 180, cmd_step = 10:
  - cur_angle steps 100, 110, …, 180 over 9 boundaries. cmd_ready = 0 throughout.
  - The final frame has a high time of 199,900.
- Send cmd_angle = 250 → target clamps to 180, and the high time settles at 199,900.
- Disable mid-slew at cur_angle = 130:
  - pwm_out = 0 the next cycle and target = 130.
  - On re-enable, frames have a high time of 172,150 and busy = 0.
- Hold cmd_valid asserted during SLEW: it is not accepted until the cycle after SLEW → HOLD, and is accepted exactly once.
